// File: rtl/log_scale_muldiv_pipe.sv
// rtl/log_scale_muldiv_pipe.sv - log-domain float multiplier/divider, 3-stage pipeline with runtime-loaded LUTs
// Optional divide path is built when LOG_MUL_DIV_EN is defined.
module log_scale_muldiv_pipe #(
    parameter int FLOAT_LEN  = 16,
    parameter int EXP_LEN    = 5,
    parameter int MANT_LEN   = 10,
    parameter int LUT_ADDR_W = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lut_wr_en,
    input  logic [MANT_LEN-1:0]  log2_lut_data_in,
    input  logic [FLOAT_LEN-1:0] exp2_lut_data_in,
    output logic                 lut_wr_done,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FLOAT_LEN-1:0] a,
    input  logic [FLOAT_LEN-1:0] b,
    input  logic                 mul_or_div,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FLOAT_LEN-1:0] result,
    output logic                 ovf,
    output logic                 unf,
    output logic                 dz
);
    localparam int LUT_SIZE = 2**LUT_ADDR_W;
    localparam int IW       = EXP_LEN + 2;          // signed integer bits of the log sum
    localparam int LW       = IW + MANT_LEN;
    localparam int SH       = MANT_LEN - LUT_ADDR_W;
    localparam int TW       = IW + LUT_ADDR_W;      // integer part plus exp2 LUT index
    localparam int EW       = EXP_LEN + 4;
    localparam int BIAS     = 2**(EXP_LEN-1) - 1;
    localparam int EMAX     = 2**EXP_LEN - 1;

`ifdef LOG_MUL_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef enum logic {ST_LOAD, ST_RUN} state_t;
    typedef enum logic [1:0] {K_NORM, K_ZERO, K_INF, K_NAN} kind_t;

    state_t                state;
    logic [LUT_ADDR_W-1:0] wr_cnt;
    logic [MANT_LEN-1:0]   log2_lut [LUT_SIZE];
    logic [FLOAT_LEN-1:0]  exp2_lut [LUT_SIZE];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_LOAD;
            wr_cnt      <= '0;
            lut_wr_done <= 1'b0;
        end else if (state == ST_LOAD && lut_wr_en) begin
            wr_cnt <= wr_cnt + LUT_ADDR_W'(1);
            if (wr_cnt == LUT_ADDR_W'(LUT_SIZE-1)) begin
                state       <= ST_RUN;
                lut_wr_done <= 1'b1;
            end
        end
    end

    // Tables are frozen once RUN is reached; only a reset reopens them.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_LOAD && lut_wr_en) begin
            log2_lut[wr_cnt] <= log2_lut_data_in;
            exp2_lut[wr_cnt] <= exp2_lut_data_in;
        end
    end

    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = (state == ST_RUN) & advance;

    logic                sa, sb;
    logic [EXP_LEN-1:0]  ea, eb;
    logic [MANT_LEN-1:0] ma, mb;
    assign {sa, ea, ma} = a;
    assign {sb, eb, mb} = b;

    logic          s1_valid, s1_sign, s1_div;
    logic [LW-1:0] s1_la, s1_lb;
    logic          s1_za, s1_zb, s1_ia, s1_ib, s1_na, s1_nb;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid & in_ready;
            s1_sign  <= sa ^ sb;
            s1_div   <= DIV_EN & mul_or_div;
            s1_la    <= {IW'(ea) - IW'(BIAS), log2_lut[ma[MANT_LEN-1 -: LUT_ADDR_W]]};
            s1_lb    <= {IW'(eb) - IW'(BIAS), log2_lut[mb[MANT_LEN-1 -: LUT_ADDR_W]]};
            s1_za    <= (ea == '0);
            s1_zb    <= (eb == '0);
            s1_ia    <= (ea == '1) && (ma == '0);
            s1_ib    <= (eb == '1) && (mb == '0);
            s1_na    <= (ea == '1) && (ma != '0);
            s1_nb    <= (eb == '1) && (mb != '0);
        end
    end

    logic [TW-1:0] l_top;
`ifdef LOG_MUL_DIV_EN
    assign l_top = TW'((s1_div ? s1_la - s1_lb : s1_la + s1_lb) >> SH);
`else
    assign l_top = TW'((s1_la + s1_lb) >> SH);
`endif

    logic nan_c, dz_c;
    always_comb begin
        nan_c = s1_na | s1_nb;
        if (s1_div)
            nan_c = nan_c | (s1_za & s1_zb) | (s1_ia & s1_ib);
        else
            nan_c = nan_c | (s1_za & s1_ib) | (s1_ia & s1_zb);
        dz_c = s1_div & s1_zb & ~s1_za;
    end

    logic          s2_valid, s2_sign, s2_dz;
    kind_t         s2_kind;
    logic [TW-1:0] s2_l_top;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_l_top <= l_top;
            s2_dz    <= 1'b0;
            if (nan_c) begin
                s2_kind <= K_NAN;
            end else if (dz_c) begin
                s2_kind <= K_INF;
                s2_dz   <= 1'b1;
            end else if (s1_ia | s1_ib) begin
                s2_kind <= K_INF;
            end else if (s1_za | s1_zb) begin
                s2_kind <= K_ZERO;
            end else begin
                s2_kind <= K_NORM;
            end
        end
    end

    logic [FLOAT_LEN-1:0] e2;
    logic signed [EW-1:0] r_exp;
    assign e2    = exp2_lut[s2_l_top[LUT_ADDR_W-1:0]];
    assign r_exp = $signed(EW'(e2[FLOAT_LEN-2 -: EXP_LEN])) + EW'($signed(s2_l_top[TW-1 -: IW]));

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            dz        <= 1'b0;
        end else if (advance) begin
            out_valid <= s2_valid;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            dz        <= 1'b0;
            if (s2_valid) begin
                case (s2_kind)
                    K_NAN:  result <= {1'b0, {EXP_LEN{1'b1}}, 1'b1, {(MANT_LEN-1){1'b0}}};
                    K_INF: begin
                        result <= {s2_sign, {EXP_LEN{1'b1}}, {MANT_LEN{1'b0}}};
                        dz     <= s2_dz;
                    end
                    K_ZERO: result <= {s2_sign, {(FLOAT_LEN-1){1'b0}}};
                    default: begin
                        if (r_exp >= $signed(EW'(EMAX))) begin
                            result <= {s2_sign, {EXP_LEN{1'b1}}, {MANT_LEN{1'b0}}};
                            ovf    <= 1'b1;
                        end else if (r_exp < $signed(EW'(1))) begin
                            result <= {s2_sign, {(FLOAT_LEN-1){1'b0}}};
                            unf    <= 1'b1;
                        end else begin
                            result <= {s2_sign ^ e2[FLOAT_LEN-1], r_exp[EXP_LEN-1:0], e2[MANT_LEN-1:0]};
                        end
                    end
                endcase
            end
        end
    end
endmodule
